// File: rtl/mem_access.sv
// Memory-access stage: registers EX results toward WB and serialises loads/stores into byte
// transactions on an 8-bit port. Optional alignment trap is built with MEM_ALIGN_CHECK_EN.
module mem_access (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic        flush_in,
    input  logic        rdE_in,
    input  logic [4:0]  rdIdx_in,
    input  logic [31:0] rdData_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [1:0]  memWidth_in,
    input  logic        memSigned_in,
    input  logic [31:0] storeData_in,
    output logic        memReq_out,
    output logic        memWe_out,
    output logic [31:0] memAddr_out,
    output logic [7:0]  memWData_out,
    input  logic [7:0]  memRData_in,
    input  logic        memReady_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic        rdE_out,
    output logic [4:0]  rdIdx_out,
    output logic [31:0] rdData_out,
    output logic        misalign_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [1:0]  width_q, width_d;
    logic        sign_q, sign_d;
    logic        we_q, we_d;
    logic [31:0] sdata_q, sdata_d;
    logic        rde_q, rde_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] buf_q, buf_d;
    logic        valid_q, valid_d;
    logic        wb_rde_q, wb_rde_d;
    logic [4:0]  wb_idx_q, wb_idx_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mis_q, mis_d;

    logic        mem_op, accept, misaligned, last_byte;
    logic [4:0]  byte_sel;
    logic [31:0] buf_next, load_result;

    assign mem_op   = memRead_in | memWrite_in;
    assign accept   = (state_q == IDLE) && valid_in && !flush_in;
    assign byte_sel = {cnt_q, 3'b000};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op && (((memWidth_in == 2'd1) && rdData_in[0]) ||
                                   ((memWidth_in[1]) && (rdData_in[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        case (width_q)
            2'd0:    last_byte = (cnt_q == 2'd0);
            2'd1:    last_byte = (cnt_q == 2'd1);
            default: last_byte = (cnt_q == 2'd3);
        endcase
    end

    // Buffer including the byte arriving this cycle, so the final ack can commit the result.
    always_comb begin
        buf_next = buf_q;
        buf_next[byte_sel +: 8] = memRData_in;
        case (width_q)
            2'd0:    load_result = sign_q ? {{24{buf_next[7]}}, buf_next[7:0]}
                                          : {24'b0, buf_next[7:0]};
            2'd1:    load_result = sign_q ? {{16{buf_next[15]}}, buf_next[15:0]}
                                          : {16'b0, buf_next[15:0]};
            default: load_result = buf_next;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        width_d   = width_q;
        sign_d    = sign_q;
        we_d      = we_q;
        sdata_d   = sdata_q;
        rde_d     = rde_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        valid_d   = 1'b0;
        wb_rde_d  = 1'b0;
        wb_idx_d  = 5'd0;
        wb_data_d = 32'd0;
        mis_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        valid_d  = 1'b1;
                        mis_d    = 1'b1;
                        wb_idx_d = rdIdx_in;
                    end else if (mem_op) begin
                        state_d = ACCESS;
                        cnt_d   = 2'd0;
                        buf_d   = 32'd0;
                        base_d  = rdData_in;
                        width_d = memWidth_in;
                        sign_d  = memSigned_in;
                        we_d    = memWrite_in;
                        sdata_d = storeData_in;
                        rde_d   = rdE_in;
                        idx_d   = rdIdx_in;
                    end else begin
                        valid_d   = 1'b1;
                        wb_rde_d  = rdE_in;
                        wb_idx_d  = rdIdx_in;
                        wb_data_d = rdData_in;
                    end
                end
            end
            ACCESS: begin
                if (memReady_in) begin
                    buf_d = buf_next;
                    cnt_d = cnt_q + 2'd1;
                    if (last_byte) begin
                        state_d   = FINISH;
                        valid_d   = 1'b1;
                        wb_idx_d  = idx_q;
                        wb_rde_d  = we_q ? 1'b0 : rde_q;
                        wb_data_d = we_q ? 32'd0 : load_result;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            base_q    <= 32'd0;
            width_q   <= 2'd0;
            sign_q    <= 1'b0;
            we_q      <= 1'b0;
            sdata_q   <= 32'd0;
            rde_q     <= 1'b0;
            idx_q     <= 5'd0;
            buf_q     <= 32'd0;
            valid_q   <= 1'b0;
            wb_rde_q  <= 1'b0;
            wb_idx_q  <= 5'd0;
            wb_data_q <= 32'd0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            width_q   <= width_d;
            sign_q    <= sign_d;
            we_q      <= we_d;
            sdata_q   <= sdata_d;
            rde_q     <= rde_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            wb_rde_q  <= wb_rde_d;
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
        end
    end

    // Byte port is driven only while an access is in flight.
    assign memReq_out   = (state_q == ACCESS);
    assign memWe_out    = (state_q == ACCESS) && we_q;
    assign memAddr_out  = (state_q == ACCESS) ? (base_q + {30'd0, cnt_q}) : 32'd0;
    assign memWData_out = (state_q == ACCESS) ? sdata_q[byte_sel +: 8] : 8'd0;
    assign stall_out    = (accept && mem_op && !misaligned) || (state_q == ACCESS);

    assign valid_out    = valid_q;
    assign rdE_out      = wb_rde_q;
    assign rdIdx_out    = wb_idx_q;
    assign rdData_out   = wb_data_q;
    assign misalign_out = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of single instructions plus hand-written
// sequences for ready stalls, reset abort, flush and the alignment option.
module tb_mem_access;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in, flush_in, rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic        memRead_in, memWrite_in;
    logic [1:0]  memWidth_in;
    logic        memSigned_in;
    logic [31:0] storeData_in;
    logic        memReq_out, memWe_out;
    logic [31:0] memAddr_out;
    logic [7:0]  memWData_out;
    logic [7:0]  memRData_in;
    logic        memReady_in;
    logic        stall_out, valid_out, rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;
    logic        misalign_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .valid_in     (valid_in),
        .flush_in     (flush_in),
        .rdE_in       (rdE_in),
        .rdIdx_in     (rdIdx_in),
        .rdData_in    (rdData_in),
        .memRead_in   (memRead_in),
        .memWrite_in  (memWrite_in),
        .memWidth_in  (memWidth_in),
        .memSigned_in (memSigned_in),
        .storeData_in (storeData_in),
        .memReq_out   (memReq_out),
        .memWe_out    (memWe_out),
        .memAddr_out  (memAddr_out),
        .memWData_out (memWData_out),
        .memRData_in  (memRData_in),
        .memReady_in  (memReady_in),
        .stall_out    (stall_out),
        .valid_out    (valid_out),
        .rdE_out      (rdE_out),
        .rdIdx_out    (rdIdx_out),
        .rdData_out   (rdData_out),
        .misalign_out (misalign_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  width;
        logic        sgn;
        logic        rde;
        logic [4:0]  idx;
        logic [31:0] addr_data;
        logic [31:0] sdata;
        logic [31:0] rbytes;
        logic [31:0] exp_data;
        logic        exp_rde;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        valid_in     = 1'b0;
        flush_in     = 1'b0;
        rdE_in       = 1'b0;
        rdIdx_in     = 5'd0;
        rdData_in    = 32'd0;
        memRead_in   = 1'b0;
        memWrite_in  = 1'b0;
        memWidth_in  = 2'd0;
        memSigned_in = 1'b0;
        storeData_in = 32'd0;
        memRData_in  = 8'd0;
        memReady_in  = 1'b0;
    endtask

    task automatic present(input vec_t v);
        valid_in     = 1'b1;
        flush_in     = 1'b0;
        rdE_in       = v.rde;
        rdIdx_in     = v.idx;
        rdData_in    = v.addr_data;
        memRead_in   = v.rd;
        memWrite_in  = v.wr;
        memWidth_in  = v.width;
        memSigned_in = v.sgn;
        storeData_in = v.sdata;
        memReady_in  = 1'b0;
    endtask

    // Applies one instruction with ready held high and checks every byte cycle and the result.
    task automatic run_vec(input string tag, input vec_t v);
        int   n;
        logic mem;
        mem = v.rd | v.wr;
        n   = (v.width == 2'd0) ? 1 : (v.width == 2'd1) ? 2 : 4;
        @(posedge clk_in); #1;
        present(v);
        @(negedge clk_in);
        check({tag, "_accept_stall"}, {31'd0, stall_out}, {31'd0, mem});
        check({tag, "_accept_req"}, {31'd0, memReq_out}, 32'd0);
        if (!mem) begin
            @(posedge clk_in); #1;
            check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
            check({tag, "_rde"}, {31'd0, rdE_out}, {31'd0, v.exp_rde});
            check({tag, "_idx"}, {27'd0, rdIdx_out}, {27'd0, v.idx});
            check({tag, "_data"}, rdData_out, v.exp_data);
            check({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
            valid_in = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                @(posedge clk_in); #1;
                memRData_in = v.rbytes[8*i +: 8];
                memReady_in = 1'b1;
                @(negedge clk_in);
                check($sformatf("%s_b%0d_req", tag, i), {31'd0, memReq_out}, 32'd1);
                check($sformatf("%s_b%0d_addr", tag, i), memAddr_out, v.addr_data + i);
                check($sformatf("%s_b%0d_we", tag, i), {31'd0, memWe_out}, {31'd0, v.wr});
                if (v.wr)
                    check($sformatf("%s_b%0d_wdata", tag, i), {24'd0, memWData_out},
                          {24'd0, v.sdata[8*i +: 8]});
                check($sformatf("%s_b%0d_stall", tag, i), {31'd0, stall_out}, 32'd1);
                check($sformatf("%s_b%0d_valid", tag, i), {31'd0, valid_out}, 32'd0);
            end
            @(posedge clk_in); #1;
            memReady_in = 1'b0;
            @(negedge clk_in);
            check({tag, "_fin_valid"}, {31'd0, valid_out}, 32'd1);
            check({tag, "_fin_rde"}, {31'd0, rdE_out}, {31'd0, v.exp_rde});
            check({tag, "_fin_idx"}, {27'd0, rdIdx_out}, {27'd0, v.idx});
            check({tag, "_fin_data"}, rdData_out, v.exp_data);
            check({tag, "_fin_stall"}, {31'd0, stall_out}, 32'd0);
            check({tag, "_fin_req"}, {31'd0, memReq_out}, 32'd0);
            @(posedge clk_in); #1;
            idle_inputs();
            @(negedge clk_in);
            check({tag, "_post_valid"}, {31'd0, valid_out}, 32'd0);
            check({tag, "_post_req"}, {31'd0, memReq_out}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'd0, memReq_out}, 32'd0);
        check({tag, "_we"}, {31'd0, memWe_out}, 32'd0);
        check({tag, "_addr"}, memAddr_out, 32'd0);
        check({tag, "_wdata"}, {24'd0, memWData_out}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check({tag, "_rde"}, {31'd0, rdE_out}, 32'd0);
        check({tag, "_idx"}, {27'd0, rdIdx_out}, 32'd0);
        check({tag, "_data"}, rdData_out, 32'd0);
        check({tag, "_mis"}, {31'd0, misalign_out}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //          rd    wr    w     sgn   rde   idx    addr/data      sdata          rbytes         exp_data       exp_rde
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 32'h0,         32'h0,         32'h0000_1234, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0,  32'hCAFE_F00D, 32'h0,         32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd10, 32'h0000_0100, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd11, 32'h0000_0040, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd12, 32'h0000_0040, 32'h0,         32'h0000_0080, 32'h0000_0080, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd13, 32'h0000_0050, 32'h0,         32'h0000_F234, 32'hFFFF_F234, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd14, 32'h0000_0050, 32'h0,         32'h0000_F234, 32'h0000_F234, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd15, 32'h0000_0052, 32'h0,         32'h0000_7FFF, 32'h0000_7FFF, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd3,  32'h0000_0300, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd31, 32'h0000_0010, 32'h0,         32'hA1B2_C3D4, 32'hA1B2_C3D4, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 5'd9,  32'h0000_0007, 32'h1122_3344, 32'h0,         32'h0,         1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd1,  32'hFFFF_FFFF, 32'h0,         32'h0000_00FE, 32'h0000_00FE, 1'b1};

        idle_inputs();
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_all_zero("reset");
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        for (int i = 0; i < 12; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // SH with ready 1-0-1 and a flush raised mid-access that must be ignored.
        v = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd6, 32'h0000_0200, 32'hAABB_CCDD, 32'h0, 32'h0, 1'b0};
        @(posedge clk_in); #1;
        present(v);
        @(posedge clk_in); #1;
        memReady_in = 1'b1;
        flush_in    = 1'b1;
        @(negedge clk_in);
        check("sh_b0_addr", memAddr_out, 32'h0000_0200);
        check("sh_b0_wdata", {24'd0, memWData_out}, 32'h0000_00DD);
        check("sh_b0_we", {31'd0, memWe_out}, 32'd1);
        @(posedge clk_in); #1;
        memReady_in = 1'b0;
        flush_in    = 1'b0;
        @(negedge clk_in);
        check("sh_hold_req", {31'd0, memReq_out}, 32'd1);
        check("sh_hold_addr", memAddr_out, 32'h0000_0201);
        check("sh_hold_wdata", {24'd0, memWData_out}, 32'h0000_00CC);
        check("sh_hold_stall", {31'd0, stall_out}, 32'd1);
        @(posedge clk_in); #1;
        memReady_in = 1'b1;
        @(negedge clk_in);
        check("sh_b1_addr", memAddr_out, 32'h0000_0201);
        check("sh_b1_wdata", {24'd0, memWData_out}, 32'h0000_00CC);
        @(posedge clk_in); #1;
        memReady_in = 1'b0;
        @(negedge clk_in);
        check("sh_fin_valid", {31'd0, valid_out}, 32'd1);
        check("sh_fin_rde", {31'd0, rdE_out}, 32'd0);
        check("sh_fin_data", rdData_out, 32'd0);
        @(posedge clk_in); #1;
        idle_inputs();

        // Reset asserted during the second byte of a word load abandons it.
        v = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd20, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b1};
        @(posedge clk_in); #1;
        present(v);
        @(posedge clk_in); #1;
        memRData_in = 8'h78;
        memReady_in = 1'b1;
        @(posedge clk_in); #1;
        memReady_in = 1'b0;
        @(negedge clk_in);
        check("rst_pre_addr", memAddr_out, 32'h0000_0101);
        check("rst_pre_req", {31'd0, memReq_out}, 32'd1);
        #2;
        rst_in = 1'b0;
        idle_inputs();
        #1;
        check_all_zero("rst_mid");
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        check_all_zero("rst_after");

        // Passthrough with rdE set, then a flushed load: no request, WB outputs cleared.
        v = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd8, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 1'b1};
        @(posedge clk_in); #1;
        present(v);
        @(posedge clk_in); #1;
        check("flush_pre_rde", {31'd0, rdE_out}, 32'd1);
        v = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 1'b1};
        present(v);
        flush_in = 1'b1;
        @(negedge clk_in);
        check("flush_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk_in); #1;
        idle_inputs();
        @(negedge clk_in);
        check_all_zero("flush");
        @(posedge clk_in); #1;
        check("flush_noreq", {31'd0, memReq_out}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        v = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd7, 32'h0000_0102, 32'h0, 32'h0, 32'h0, 1'b0};
        @(posedge clk_in); #1;
        present(v);
        @(negedge clk_in);
        check("mis_stall", {31'd0, stall_out}, 32'd0);
        check("mis_req0", {31'd0, memReq_out}, 32'd0);
        @(posedge clk_in); #1;
        idle_inputs();
        @(negedge clk_in);
        check("mis_flag", {31'd0, misalign_out}, 32'd1);
        check("mis_valid", {31'd0, valid_out}, 32'd1);
        check("mis_rde", {31'd0, rdE_out}, 32'd0);
        check("mis_req1", {31'd0, memReq_out}, 32'd0);
        @(posedge clk_in); #1;
        check("mis_flag_drop", {31'd0, misalign_out}, 32'd0);
        check("mis_req2", {31'd0, memReq_out}, 32'd0);
`else
        // Misaligned word crossing the top of the address space proceeds byte-wise with wrap.
        v = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 5'd21, 32'hFFFF_FFFE, 32'h0, 32'h8899_AABB, 32'h8899_AABB, 1'b1};
        run_vec("wrap", v);
        check("wrap_mis", {31'd0, misalign_out}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
